// File: rtl/rowwise_div_seq.sv
// rtl/rowwise_div_seq.sv - multi-cycle signed fixed-point divider, radix-2 restoring, saturating
module rowwise_div_seq #(
  parameter int DataWidth = 16,
  parameter int FracBits  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] y_o,
  output logic                 sat_o
);

  localparam int N    = DataWidth + FracBits;
  localparam int CntW = $clog2(N + 1);

  localparam logic [DataWidth-1:0] Zero   = '0;
  localparam logic [DataWidth-1:0] FixMax = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic [DataWidth-1:0] FixMin = {1'b1, {(DataWidth-1){1'b0}}};
  localparam logic [N-1:0]         PosLim = N'(2**(DataWidth-1) - 1);
  localparam logic [N-1:0]         NegLim = N'(2**(DataWidth-1));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [N-1:0]         dividend;
  logic [DataWidth-1:0] divisor;
  logic [DataWidth-1:0] rem;
  logic [N-1:0]         quot;
  logic [CntW-1:0]      cnt;
  logic                 neg, b_zero, a_sign, a_nz;

  logic                 accept, calc_last;
  logic [DataWidth-1:0] a_mag, b_mag;
  logic [DataWidth:0]   rem_shift, trial;
  logic [DataWidth-1:0] res_y;
  logic                 res_sat;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign accept      = in_valid_i & in_ready_o;
  assign calc_last   = (state == CALC) && (cnt == '0);

  // Modular negation in DataWidth bits yields the exact unsigned magnitude, including for the most negative value.
  assign a_mag = a_i[DataWidth-1] ? (Zero - a_i) : a_i;
  assign b_mag = b_i[DataWidth-1] ? (Zero - b_i) : b_i;

  assign rem_shift = {rem, dividend[N-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_y   = '0;
    res_sat = 1'b0;
    if (b_zero) begin
      if (a_nz) begin
        res_sat = 1'b1;
        res_y   = a_sign ? FixMin : FixMax;
      end
    end else if (!neg) begin
      if (quot > PosLim) begin
        res_y   = FixMax;
        res_sat = 1'b1;
      end else begin
        res_y = quot[DataWidth-1:0];
      end
    end else begin
      if (quot > NegLim) begin
        res_y   = FixMin;
        res_sat = 1'b1;
      end else begin
        res_y = Zero - quot[DataWidth-1:0];
      end
    end
  end

  // A zero divisor enters CALC with cnt=0, so its result lands one cycle after accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      b_zero   <= 1'b0;
      a_sign   <= 1'b0;
      a_nz     <= 1'b0;
      y_o      <= '0;
      sat_o    <= 1'b0;
    end else begin
      if (accept) begin
        dividend <= {a_mag, {FracBits{1'b0}}};
        divisor  <= b_mag;
        rem      <= '0;
        quot     <= '0;
        cnt      <= (b_i == Zero) ? '0 : CntW'(N);
        neg      <= a_i[DataWidth-1] ^ b_i[DataWidth-1];
        b_zero   <= (b_i == Zero);
        a_sign   <= a_i[DataWidth-1];
        a_nz     <= |a_i;
      end else if (state == CALC && cnt != '0) begin
        dividend <= dividend << 1;
        rem      <= trial[DataWidth] ? rem_shift[DataWidth-1:0] : trial[DataWidth-1:0];
        quot     <= {quot[N-2:0], ~trial[DataWidth]};
        cnt      <= cnt - CntW'(1);
      end
      if (calc_last) begin
        y_o   <= res_y;
        sat_o <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_rowwise_div_seq.sv
// tb/tb_rowwise_div_seq.sv - directed and random checks of rowwise_div_seq
module tb_rowwise_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, sat;
  logic [15:0] a_in, b_in, y;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        sat;
  } vec_t;

  vec_t vecs[$];

  rowwise_div_seq #(.DataWidth(16), .FracBits(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_in), .b_i(b_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y), .sat_o(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] ry, output logic rs);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rs = 1'b0;
    ry = 16'h0000;
    if (sb == 0) begin
      if (sa > 0)      begin ry = 16'h7FFF; rs = 1'b1; end
      else if (sa < 0) begin ry = 16'h8000; rs = 1'b1; end
    end else begin
      q = (sa * 256) / sb;
      if (q > 32767)       begin ry = 16'h7FFF; rs = 1'b1; end
      else if (q < -32768) begin ry = 16'h8000; rs = 1'b1; end
      else                 ry = q[15:0];
    end
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ey,
                       input logic es, input int elat, input int hold, input bit noise,
                       input string tag);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b0;
    #1 check(tag, "in_ready before accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = noise ? 1'($urandom) : 1'b0;
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    check(tag, "latency", lat, elat);
    check(tag, "y", 32'(y), 32'(ey));
    check(tag, "sat", 32'(sat), 32'(es));
    check(tag, "in_ready in DONE", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check(tag, "held out_valid", 32'(out_valid), 32'd1);
      check(tag, "held y", 32'(y), 32'(ey));
      check(tag, "held sat", 32'(sat), 32'(es));
      check(tag, "held in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check(tag, "out_valid after handshake", 32'(out_valid), 32'd0);
    check(tag, "in_ready after handshake", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb, ey;
    logic        es;

    vecs.push_back('{16'h0300, 16'h0200, 16'h0180, 1'b0});
    vecs.push_back('{16'hFD00, 16'h0200, 16'hFE80, 1'b0});
    vecs.push_back('{16'h0001, 16'h0300, 16'h0000, 1'b0});
    vecs.push_back('{16'h7F00, 16'h0080, 16'h7FFF, 1'b1});
    vecs.push_back('{16'h8000, 16'hFF00, 16'h7FFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h0100, 16'h8000, 1'b0});
    vecs.push_back('{16'h0005, 16'h0000, 16'h7FFF, 1'b1});
    vecs.push_back('{16'hFFFB, 16'h0000, 16'h8000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{16'h0100, 16'hFD00, 16'hFFAB, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h0001, 16'h8000, 1'b1});
    vecs.push_back('{16'h0080, 16'hFF80, 16'hFF00, 1'b0});
    vecs.push_back('{16'hFF80, 16'h0100, 16'hFF80, 1'b0});
    vecs.push_back('{16'h4000, 16'h0200, 16'h2000, 1'b0});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", "in_ready", 32'(in_ready), 32'd1);
    check("reset", "out_valid", 32'(out_valid), 32'd0);
    check("reset", "y", 32'(y), 32'd0);
    check("reset", "sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].sat,
            (vecs[i].b == 16'h0000) ? 1 : 25, 0, 1'b0, $sformatf("vec%0d", i));

    do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 25, 10, 1'b0, "backpressure");

    @(negedge clk);
    in_valid = 1'b1; a_in = 16'h0300; b_in = 16'h0200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset", "in_ready", 32'(in_ready), 32'd1);
    check("midreset", "out_valid", 32'(out_valid), 32'd0);
    check("midreset", "y", 32'(y), 32'd0);
    check("midreset", "sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1 check("midreset", "no stray result", 32'(out_valid), 32'd0);
    end
    do_op(16'h7F00, 16'h0200, 16'h3F80, 1'b0, 25, 0, 1'b0, "after_reset");

    for (int k = 0; k < 400; k++) begin
      int sel;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      sel = int'($urandom % 8);
      if (sel == 0)     rb = 16'h0000;
      else if (sel < 3) rb = {{8{rb[15]}}, rb[7:0]};
      ref_div(ra, rb, ey, es);
      repeat ($urandom % 4) @(negedge clk);
      do_op(ra, rb, ey, es, (rb == 16'h0000) ? 1 : 25, int'($urandom % 3), 1'b1,
            $sformatf("rnd%0d a=%h b=%h", k, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
